core_store_unit: RTL and testbench
==================================

# core_store_unit

Store-side data memory interface of the core: the write-direction counterpart of the writeback load sizing path. Accepts one store per handshake from the MEM stage, checks alignment, replicates store data onto the 32-bit bus lanes, and generates byte enables. Drives a request/grant/acknowledge write transaction to data memory and holds the pipeline until the write completes.

## Interface
- XLEN, 32, data and address width; only 32 is supported.
- i_clk  input  1  core clock; all state updates on the rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_st_valid  input  1  MEM stage presents a store this cycle.
- i_d_size  input  2  00 byte, 01 halfword, 11 word; 10 reserved, treated as word.
- i_addr  input  XLEN  byte address of the store.
- i_st_data  input  XLEN  rs2 value; the low bytes are significant per size.
- o_st_ready  output  1  unit can accept; a store is taken when i_st_valid && o_st_ready.
- o_stall  output  1  i_st_valid && !o_st_ready; the pipeline must hold MEM inputs stable.
- o_misaligned  output  1  one-cycle pulse: the accepted store was misaligned and was dropped.
- o_misaligned_addr  output  XLEN  address of the last misaligned store; held until the next one.
- o_bus_err  output  1  one-cycle pulse: memory returned an error acknowledge.
- o_dmem_req  output  1  write request valid.
- o_dmem_addr  output  XLEN  word address, {i_addr[XLEN-1:2], 2'b00}.
- o_dmem_wdata  output  XLEN  lane-replicated write data.
- o_dmem_be  output  4  byte enables, bit k = byte lane k.
- i_dmem_gnt  input  1  memory accepts the request this cycle.
- i_dmem_ack  input  1  write completed.
- i_dmem_err  input  1  qualifies i_dmem_ack as an error completion.

## Operation
- FSM states: IDLE, REQ, WAIT_ACK.
- IDLE:
  - o_st_ready = 1, except while i_rst = 1.
  - On a handshake, register addr, wdata and be.
  - If the store is aligned, go to REQ.
  - If misaligned, stay in IDLE, pulse o_misaligned the next cycle and load o_misaligned_addr. No bus activity.
- Misaligned conditions:
  - Halfword with addr[0] = 1.
  - Word or reserved size with addr[1:0] != 0.
  - A byte store is never misaligned.
- REQ:
  - o_dmem_req = 1. addr, wdata and be are held stable until grant.
  - i_dmem_gnt && i_dmem_ack in the same cycle: go to IDLE.
  - i_dmem_gnt alone: go to WAIT_ACK.
- WAIT_ACK: o_dmem_req = 0; on i_dmem_ack go to IDLE.
- o_bus_err pulses the cycle after any ack with i_dmem_err = 1. The store is still retired; there is no retry.
- Lane mapping, with a = addr[1:0]:
  - Byte: wdata = {4{data[7:0]}}, be = 4'b0001 << a.
  - Half: wdata = {2{data[15:0]}}, be = a[1] ? 4'b1100 : 4'b0011.
  - Word: wdata = data, be = 4'b1111.
- i_dmem_ack outside REQ/WAIT_ACK and i_dmem_gnt outside REQ are ignored.
- o_dmem_addr, o_dmem_wdata and o_dmem_be are don't-care when o_dmem_req = 0, but stay at the registered values.

## Timing
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - o_dmem_req, o_misaligned and o_bus_err = 0; o_dmem_addr, o_dmem_wdata, o_dmem_be and o_misaligned_addr = 0.
  - o_st_ready = 0 during any cycle with i_rst = 1.
- Reset mid-transaction (REQ or WAIT_ACK): o_dmem_req drops at the next edge. A late ack after reset is ignored.
- Handshake at edge N: o_dmem_req is high in cycle N+1; o_st_ready is low from N+1.
- Best case, gnt + ack in cycle N+1: IDLE and o_st_ready high in N+2. Maximum throughput is one store per 2 cycles.
- gnt at N+1 and ack at N+k: o_st_ready is high at N+k+1.
- Misaligned store at edge N: o_misaligned is high for cycle N+1 only; o_st_ready stays 1 throughout.
- o_stall is combinational from i_st_valid and state; there is no other combinational path from bus inputs to outputs.

## Test plan
- Byte store sb, addr 0x1003, data 0xAABBCCDD, gnt+ack immediate -> o_dmem_addr 0x1000, wdata 0xDDDDDDDD, be 4'b1000; o_dmem_req high exactly 1 cycle; o_st_ready back high 2 cycles after accept.
- Half store sh, addr 0x2002, data 0x12345678; gnt delayed 3 cycles, ack 2 cycles after gnt -> wdata 0x56785678, be 4'b1100, outputs stable until gnt; o_stall asserted for a back-to-back store until ack+1.
- Word store at 0x3001 -> o_misaligned 1-cycle pulse, o_misaligned_addr 0x3001, o_dmem_req never asserts; the next aligned sw at 0x3004 proceeds normally.
- Ack with i_dmem_err = 1 on sw 0x4000 -> o_bus_err pulse the next cycle, FSM returns to IDLE; a spurious ack in IDLE -> no state change, no pulse.
- i_rst asserted in REQ and, separately, in WAIT_ACK -> o_dmem_req low and all outputs zero at the next edge, o_st_ready high the cycle after i_rst drops; a late ack is ignored.
- Reserved size 2'b10, addr 0x5000, data 0xCAFEF00D -> treated as word: be 4'b1111, wdata 0xCAFEF00D.

Source files
------------

// File: rtl/core_store_unit.sv
// core_store_unit: store-side data memory write port.
// Takes one store per handshake, checks alignment, lane-replicates data,
// builds byte enables and runs a req/gnt/ack write to data memory.
module core_store_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_st_valid,
    input  logic [1:0]      i_d_size,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_st_data,
    output logic            o_st_ready,
    output logic            o_stall,
    output logic            o_misaligned,
    output logic [XLEN-1:0] o_misaligned_addr,
    output logic            o_bus_err,
    output logic            o_dmem_req,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    output logic [3:0]      o_dmem_be,
    input  logic            i_dmem_gnt,
    input  logic            i_dmem_ack,
    input  logic            i_dmem_err
);

    localparam int unsigned BE_W  = 4;
    localparam int unsigned OFF_W = 2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic            accept;
    logic            aligned;
    logic            complete;
    logic [XLEN-1:0] lane_data;
    logic [BE_W-1:0] lane_be;
    logic [OFF_W-1:0] offset;

    assign offset = i_addr[OFF_W-1:0];

    // Size decode: alignment check, lane replication and byte enables.
    // Reserved size 2'b10 falls through to the word case.
    always_comb begin
        lane_data = i_st_data;
        lane_be   = BE_W'(4'b1111);
        aligned   = (offset == 2'b00);
        case (i_d_size)
            SZ_BYTE: begin
                lane_data = {4{i_st_data[7:0]}};
                lane_be   = BE_W'(4'b0001) << offset;
                aligned   = 1'b1;
            end
            SZ_HALF: begin
                lane_data = {2{i_st_data[15:0]}};
                lane_be   = offset[1] ? BE_W'(4'b1100) : BE_W'(4'b0011);
                aligned   = ~offset[0];
            end
            default: begin
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state, handshake and bus request decode.
    always_comb begin
        state_next = state;
        o_st_ready = 1'b0;
        o_dmem_req = 1'b0;
        accept     = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                o_st_ready = ~i_rst;
                accept     = i_st_valid & ~i_rst;
                if (accept && aligned) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                o_dmem_req = 1'b1;
                if (i_dmem_gnt) begin
                    if (i_dmem_ack) begin
                        complete   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                if (i_dmem_ack) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_stall = i_st_valid & ~o_st_ready;

    // Transaction payload captured on every accepted store; held until the next.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_dmem_addr  <= '0;
            o_dmem_wdata <= '0;
            o_dmem_be    <= '0;
        end else if (accept) begin
            o_dmem_addr  <= {i_addr[XLEN-1:OFF_W], OFF_W'(0)};
            o_dmem_wdata <= lane_data;
            o_dmem_be    <= lane_be;
        end
    end

    // Status pulses: misaligned drop and error completion.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_misaligned      <= 1'b0;
            o_misaligned_addr <= '0;
            o_bus_err         <= 1'b0;
        end else begin
            o_misaligned <= accept & ~aligned;
            o_bus_err    <= complete & i_dmem_err;
            if (accept && !aligned) begin
                o_misaligned_addr <= i_addr;
            end
        end
    end

endmodule

// File: tb/tb_core_store_unit.sv
// Scoreboarded bench for core_store_unit: directed scenarios plus random stores.
module tb_core_store_unit;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            st_valid;
    logic [1:0]      d_size;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] st_data;
    logic            st_ready;
    logic            stall;
    logic            misaligned;
    logic [XLEN-1:0] misaligned_addr;
    logic            bus_err;
    logic            dmem_req;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_be;
    logic            gnt;
    logic            ack;
    logic            err;

    core_store_unit #(.XLEN(XLEN)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_st_valid        (st_valid),
        .i_d_size          (d_size),
        .i_addr            (addr),
        .i_st_data         (st_data),
        .o_st_ready        (st_ready),
        .o_stall           (stall),
        .o_misaligned      (misaligned),
        .o_misaligned_addr (misaligned_addr),
        .o_bus_err         (bus_err),
        .o_dmem_req        (dmem_req),
        .o_dmem_addr       (dmem_addr),
        .o_dmem_wdata      (dmem_wdata),
        .o_dmem_be         (dmem_be),
        .i_dmem_gnt        (gnt),
        .i_dmem_ack        (ack),
        .i_dmem_err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          mis;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    exp_t acc_q[$];
    exp_t wr_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference: a store of nb bytes occupies lanes [off, off+nb), lane k carries data byte k%nb.
    function automatic exp_t model(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        exp_t m;
        int nb;
        int lo;
        int off;
        nb  = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
        lo  = int'(a[1:0]);
        off = lo - (lo % nb);
        m.mis   = (lo % nb) != 0;
        m.addr  = m.mis ? a : {a[31:2], 2'b00};
        m.be    = 4'b0000;
        m.wdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            m.be[k] = (k >= off) && (k < off + nb);
            m.wdata[8*k +: 8] = d[8*(k % nb) +: 8];
        end
        return m;
    endfunction

    // Monitor: pulses and bus payload checked against the scoreboard every cycle.
    initial begin : monitor
        bit          armed;
        bit          exp_mis;
        bit          exp_err;
        bit          waiting;
        bit          nmis;
        bit          nerr;
        logic [31:0] exp_mis_addr;
        exp_t        e;
        armed = 0; exp_mis = 0; exp_err = 0; waiting = 0; exp_mis_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (armed) begin
                chk1("misaligned_pulse", misaligned, exp_mis);
                chk32("misaligned_addr", misaligned_addr, exp_mis_addr);
                chk1("bus_err_pulse", bus_err, exp_err);
                chk1("stall", stall, st_valid && !st_ready);
            end
            nmis = 0;
            nerr = 0;
            if (rst) begin
                chk1("ready_in_reset", st_ready, 1'b0);
                armed = 1;
                waiting = 0;
                exp_mis_addr = 32'h0;
                wr_q.delete();
            end else if (armed) begin
                if (ack && waiting) begin
                    nerr = err;
                    waiting = 0;
                end
                if (dmem_req) begin
                    if (wr_q.size() == 0) begin
                        fail_now("unexpected_dmem_req");
                    end else begin
                        chk32("dmem_addr", dmem_addr, wr_q[0].addr);
                        chk32("dmem_wdata", dmem_wdata, wr_q[0].wdata);
                        chk32("dmem_be", {28'h0, dmem_be}, {28'h0, wr_q[0].be});
                        if (gnt) begin
                            void'(wr_q.pop_front());
                            if (ack) nerr = err;
                            else     waiting = 1;
                        end
                    end
                end
                if (st_valid && st_ready) begin
                    if (acc_q.size() == 0) begin
                        fail_now("unexpected_accept");
                    end else begin
                        e = acc_q.pop_front();
                        if (e.mis) begin
                            nmis = 1;
                            exp_mis_addr = e.addr;
                        end else begin
                            wr_q.push_back(e);
                        end
                    end
                end
            end
            exp_mis = nmis;
            exp_err = nerr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one store and play the memory side with gd cycles to grant, ad cycles grant-to-ack.
    task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                         input int gd, input int ad, input bit e, input bit keep);
        exp_t m;
        int   n;
        m = model(sz, a, d);
        d_size = sz; addr = a; st_data = d; st_valid = 1'b1;
        #1;
        n = 0;
        while (!st_ready && n < 64) begin
            tick();
            n++;
        end
        if (!st_ready) begin
            fail_now("accept_timeout");
            st_valid = 1'b0;
            return;
        end
        acc_q.push_back(m);
        tick();
        if (!keep || m.mis) st_valid = 1'b0;
        if (m.mis) begin
            chk1("mis_pulse_hi", misaligned, 1'b1);
            chk32("mis_addr_load", misaligned_addr, a);
            chk1("mis_no_req", dmem_req, 1'b0);
            chk1("mis_ready_kept", st_ready, 1'b1);
            tick();
            chk1("mis_pulse_lo", misaligned, 1'b0);
            chk1("mis_no_req2", dmem_req, 1'b0);
            return;
        end
        chk1("req_after_accept", dmem_req, 1'b1);
        chk1("busy_after_accept", st_ready, 1'b0);
        if (keep) chk1("stall_busy", stall, 1'b1);
        repeat (gd) begin
            tick();
            chk1("req_held", dmem_req, 1'b1);
            if (keep) chk1("stall_req", stall, 1'b1);
        end
        gnt = 1'b1;
        if (ad == 0) begin
            ack = 1'b1;
            err = e;
        end
        tick();
        gnt = 1'b0; ack = 1'b0; err = 1'b0;
        if (ad > 0) begin
            chk1("req_low_wait", dmem_req, 1'b0);
            chk1("busy_wait", st_ready, 1'b0);
            repeat (ad - 1) begin
                tick();
                chk1("req_low_wait2", dmem_req, 1'b0);
                if (keep) chk1("stall_wait", stall, 1'b1);
            end
            ack = 1'b1;
            err = e;
            tick();
            ack = 1'b0; err = 1'b0;
        end
        chk1("ready_after_ack", st_ready, 1'b1);
        chk1("req_low_done", dmem_req, 1'b0);
        chk1("bus_err_done", bus_err, e);
        if (keep) chk1("stall_released", stall, 1'b0);
    endtask

    // Reset asserted while in REQ (in_wait=0) or WAIT_ACK (in_wait=1), then a late ack.
    task automatic reset_mid(input bit in_wait);
        acc_q.push_back(model(2'b11, 32'h0000_6000, 32'h1122_3344));
        d_size = 2'b11; addr = 32'h0000_6000; st_data = 32'h1122_3344; st_valid = 1'b1;
        tick();
        st_valid = 1'b0;
        chk1("rst_mid_req", dmem_req, 1'b1);
        if (in_wait) begin
            gnt = 1'b1;
            tick();
            gnt = 1'b0;
            chk1("rst_mid_wait", dmem_req, 1'b0);
            chk1("rst_mid_busy", st_ready, 1'b0);
        end
        rst = 1'b1;
        tick();
        chk1("rst_req_low", dmem_req, 1'b0);
        chk1("rst_ready_low", st_ready, 1'b0);
        chk32("rst_dmem_addr", dmem_addr, 32'h0);
        chk32("rst_dmem_wdata", dmem_wdata, 32'h0);
        chk32("rst_dmem_be", {28'h0, dmem_be}, 32'h0);
        chk32("rst_mis_addr", misaligned_addr, 32'h0);
        chk1("rst_mis", misaligned, 1'b0);
        chk1("rst_bus_err", bus_err, 1'b0);
        rst = 1'b0;
        ack = 1'b1;
        err = 1'b1;
        #1;
        chk1("rst_ready_back", st_ready, 1'b1);
        tick();
        ack = 1'b0; err = 1'b0;
        chk1("late_ack_no_err", bus_err, 1'b0);
        chk1("late_ack_no_req", dmem_req, 1'b0);
        chk1("late_ack_ready", st_ready, 1'b1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [1:0]  sz;
        logic [31:0] a;
        rst = 1'b1; st_valid = 1'b0; d_size = 2'b00; addr = 32'h0; st_data = 32'h0;
        gnt = 1'b0; ack = 1'b0; err = 1'b0;
        tick();
        tick();
        chk1("reset_ready", st_ready, 1'b0);
        chk1("reset_req", dmem_req, 1'b0);
        chk32("reset_dmem_addr", dmem_addr, 32'h0);
        chk32("reset_mis_addr", misaligned_addr, 32'h0);
        chk1("reset_mis", misaligned, 1'b0);
        chk1("reset_bus_err", bus_err, 1'b0);
        rst = 1'b0;
        #1;
        chk1("ready_after_reset", st_ready, 1'b1);
        tick();

        store(2'b00, 32'h0000_1003, 32'hAABB_CCDD, 0, 0, 1'b0, 1'b0);
        store(2'b01, 32'h0000_2002, 32'h1234_5678, 3, 2, 1'b0, 1'b1);
        store(2'b11, 32'h0000_3001, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0);
        store(2'b11, 32'h0000_3004, 32'h0BAD_F00D, 1, 1, 1'b0, 1'b0);
        store(2'b11, 32'h0000_4000, 32'h5555_AAAA, 0, 1, 1'b1, 1'b0);
        ack = 1'b1; err = 1'b1;
        tick();
        ack = 1'b0; err = 1'b0;
        chk1("spurious_ack_no_err", bus_err, 1'b0);
        chk1("spurious_ack_ready", st_ready, 1'b1);
        chk1("spurious_ack_no_req", dmem_req, 1'b0);
        store(2'b10, 32'h0000_5000, 32'hCAFE_F00D, 0, 0, 1'b0, 1'b0);
        reset_mid(1'b0);
        reset_mid(1'b1);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                st_valid = 1'b0;
                ack = 1'b1;
                err = 1'($urandom_range(0, 1));
                tick();
                ack = 1'b0; err = 1'b0;
            end
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            store(sz, a, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 5) == 0, (i != 149) && ($urandom_range(0, 3) == 0));
        end
        st_valid = 1'b0;
        repeat (3) tick();
        chk32("accept_queue_drained", 32'(acc_q.size()), 32'h0);
        chk32("write_queue_drained", 32'(wr_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
